ram_2p_arbiter: RTL and testbench

// - Shares one prim_generic_ram_2p instance between NumReq requesters; grants up to two per cycle (RAM port A, port B).
// - Round-robin fairness; same-address hazards resolved by granting only one; read data routed back to the owner.
// - Built-in init FSM zeroes the whole RAM through both ports (boot and secure wipe).
// - Sits between the RAM and the requesters; it is the only RAM master.
//

---
 rtl/ram_2p_arb_pkg.sv | 14 +
 rtl/ram_2p_rr_pick.sv | 50 +++++
 rtl/ram_2p_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_2p_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_2p_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
package ram_2p_arb_pkg;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbInit = 1'b1
  } arb_state_e;

  // Cyclic successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ram_2p_rr_pick.sv
// Round-robin picker: first set request at or after ptr, then the next set one after it.
module ram_2p_rr_pick #(
  parameter int NumReq = 4,
  parameter int Pw     = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [Pw-1:0]     ptr_i,
  output logic              first_vld_o,
  output logic [Pw-1:0]     first_idx_o,
  output logic [NumReq-1:0] first_oh_o,
  output logic              second_vld_o,
  output logic [Pw-1:0]     second_idx_o,
  output logic [NumReq-1:0] second_oh_o
);

  logic [NumReq-1:0] masked;

  function automatic logic [Pw-1:0] wrap(input int v);
    return Pw'(v % NumReq);
  endfunction

  always_comb begin
    first_vld_o = 1'b0;
    first_idx_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!first_vld_o && req_i[wrap(int'(ptr_i) + i)]) begin
        first_vld_o = 1'b1;
        first_idx_o = wrap(int'(ptr_i) + i);
      end
    end
  end

  assign first_oh_o = first_vld_o ? (NumReq'(1) << first_idx_o) : '0;
  assign masked     = req_i & ~first_oh_o;

  // Second search starts just after the first winner so port B keeps cyclic order.
  always_comb begin
    second_vld_o = 1'b0;
    second_idx_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!second_vld_o && masked[wrap(int'(first_idx_o) + 1 + i)]) begin
        second_vld_o = 1'b1;
        second_idx_o = wrap(int'(first_idx_o) + 1 + i);
      end
    end
  end

  assign second_oh_o = second_vld_o ? (NumReq'(1) << second_idx_o) : '0;

endmodule

// File: rtl/ram_2p_arbiter.sv
// Shares one two-port RAM between NumReq requesters (two grants per cycle) and zeroes it on demand.
module ram_2p_arbiter
  import ram_2p_arb_pkg::*;
#(
  parameter int  Width  = 32,
  parameter int  Depth  = 128,
  parameter int  NumReq = 4,
  localparam int Aw     = $clog2(Depth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     init_req_i,
  output logic                     init_busy_o,
  output logic                     init_done_o,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        write_i,
  input  logic [NumReq*Aw-1:0]     addr_i,
  input  logic [NumReq*Width-1:0]  wdata_i,
  input  logic [NumReq*Width-1:0]  wmask_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [NumReq*Width-1:0]  rdata_o,
  output logic                     ram_a_req_o,
  output logic                     ram_a_write_o,
  output logic [Aw-1:0]            ram_a_addr_o,
  output logic [Width-1:0]         ram_a_wdata_o,
  output logic [Width-1:0]         ram_a_wmask_o,
  input  logic [Width-1:0]         ram_a_rdata_i,
  output logic                     ram_b_req_o,
  output logic                     ram_b_write_o,
  output logic [Aw-1:0]            ram_b_addr_o,
  output logic [Width-1:0]         ram_b_wdata_o,
  output logic [Width-1:0]         ram_b_wmask_o,
  input  logic [Width-1:0]         ram_b_rdata_i
);

  localparam int          Pw     = $clog2(NumReq);
  localparam logic [Aw:0] DepthC = (Aw+1)'(Depth);

  arb_state_e          state_q;
  logic [Aw:0]         cnt_q, cnt_p1, cnt_p2;
  logic                busy_q, done_q;
  logic [Pw-1:0]       ptr_q, ptr_d, last_idx;
  logic                rd_a_q, rd_b_q;
  logic [Pw-1:0]       own_a_q, own_b_q;
  logic [NumReq*Width-1:0] rdata_q;

  logic                f_vld, s_vld, f_wr, s_wr, hazard, idle, gnt_a, gnt_b;
  logic [Pw-1:0]       f_idx, s_idx;
  logic [NumReq-1:0]   f_oh, s_oh;
  logic [Aw-1:0]       f_addr, s_addr;

  ram_2p_rr_pick #(.NumReq(NumReq), .Pw(Pw)) u_pick (
    .req_i        (req_i),
    .ptr_i        (ptr_q),
    .first_vld_o  (f_vld),
    .first_idx_o  (f_idx),
    .first_oh_o   (f_oh),
    .second_vld_o (s_vld),
    .second_idx_o (s_idx),
    .second_oh_o  (s_oh)
  );

  assign f_addr = addr_i[f_idx*Aw +: Aw];
  assign s_addr = addr_i[s_idx*Aw +: Aw];
  assign f_wr   = write_i[f_idx];
  assign s_wr   = write_i[s_idx];
  // Same word touched by both ports with a write involved: only the first may proceed.
  assign hazard = f_vld && s_vld && (f_addr == s_addr) && (f_wr || s_wr);
  assign idle   = (state_q == ArbIdle);
  assign gnt_a  = idle && f_vld;
  assign gnt_b  = idle && s_vld && !hazard;
  assign gnt_o  = (gnt_a ? f_oh : '0) | (gnt_b ? s_oh : '0);

  assign last_idx = gnt_b ? s_idx : f_idx;
  assign ptr_d    = gnt_a ? Pw'(rr_next(int'(last_idx), NumReq)) : ptr_q;
  assign cnt_p1   = cnt_q + (Aw+1)'(1);
  assign cnt_p2   = cnt_q + (Aw+1)'(2);

  always_comb begin
    ram_a_req_o   = gnt_a;
    ram_a_write_o = f_wr;
    ram_a_addr_o  = f_addr;
    ram_a_wdata_o = wdata_i[f_idx*Width +: Width];
    ram_a_wmask_o = wmask_i[f_idx*Width +: Width];
    ram_b_req_o   = gnt_b;
    ram_b_write_o = s_wr;
    ram_b_addr_o  = s_addr;
    ram_b_wdata_o = wdata_i[s_idx*Width +: Width];
    ram_b_wmask_o = wmask_i[s_idx*Width +: Width];
    if (!idle) begin
      ram_a_req_o   = 1'b1;
      ram_a_write_o = 1'b1;
      ram_a_addr_o  = cnt_q[Aw-1:0];
      ram_a_wdata_o = '0;
      ram_a_wmask_o = '1;
      ram_b_req_o   = (cnt_p1 < DepthC);
      ram_b_write_o = 1'b1;
      ram_b_addr_o  = cnt_p1[Aw-1:0];
      ram_b_wdata_o = '0;
      ram_b_wmask_o = '1;
    end
  end

  // Response mux: RAM data goes to the registered owner, otherwise hold the last value.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = rdata_q;
    if (rd_a_q) begin
      rvalid_o[own_a_q]                 = 1'b1;
      rdata_o[own_a_q*Width +: Width]   = ram_a_rdata_i;
    end
    if (rd_b_q) begin
      rvalid_o[own_b_q]                 = 1'b1;
      rdata_o[own_b_q*Width +: Width]   = ram_b_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      rd_a_q  <= 1'b0;
      rd_b_q  <= 1'b0;
      own_a_q <= '0;
      own_b_q <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rd_a_q  <= gnt_a && !f_wr;
      rd_b_q  <= gnt_b && !s_wr;
      own_a_q <= f_idx;
      own_b_q <= s_idx;
      rdata_q <= rdata_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ArbIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ArbIdle: begin
          if (init_req_i) begin
            state_q <= ArbInit;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ArbInit: begin
          cnt_q <= cnt_p2;
          if (cnt_p2 >= DepthC) begin
            state_q <= ArbIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign init_busy_o = busy_q;
  assign init_done_o = done_q;

endmodule

// File: tb/tb_ram_2p_arbiter.sv
// Scoreboard bench for ram_2p_arbiter with a behavioural two-port RAM behind it.
module tb_ram_2p_arbiter;
  localparam int W = 32, D = 128, NR = 4, AW = 7, AW5 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              init_req, busy, done;
  logic [NR-1:0]     req, wr, gnt, rvalid;
  logic [NR*AW-1:0]  addr;
  logic [NR*W-1:0]   wdata, wmask, rdata;
  logic              a_req, a_wr, b_req, b_wr;
  logic [AW-1:0]     a_addr, b_addr;
  logic [W-1:0]      a_wdata, a_wmask, a_rdata, b_wdata, b_wmask, b_rdata;

  logic [AW-1:0]     s_addr  [NR];
  logic [W-1:0]      s_wdata [NR];
  logic [W-1:0]      s_exp   [NR];

  logic              init5, busy5, done5, a_req5, a_wr5, b_req5, b_wr5;
  logic [NR-1:0]     gnt5, rvalid5;
  logic [NR*W-1:0]   rdata5;
  logic [AW5-1:0]    a_addr5, b_addr5;
  logic [W-1:0]      a_wdata5, a_wmask5, b_wdata5, b_wmask5;

  always_comb begin
    addr  = '0;
    wdata = '0;
    for (int k = 0; k < NR; k++) begin
      addr[k*AW +: AW] = s_addr[k];
      wdata[k*W +: W]  = s_wdata[k];
    end
  end
  assign wmask = '1;

  ram_2p_arbiter #(.Width(W), .Depth(D), .NumReq(NR)) u_dut (
    .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .init_busy_o(busy), .init_done_o(done),
    .req_i(req), .write_i(wr), .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .ram_a_req_o(a_req), .ram_a_write_o(a_wr), .ram_a_addr_o(a_addr),
    .ram_a_wdata_o(a_wdata), .ram_a_wmask_o(a_wmask), .ram_a_rdata_i(a_rdata),
    .ram_b_req_o(b_req), .ram_b_write_o(b_wr), .ram_b_addr_o(b_addr),
    .ram_b_wdata_o(b_wdata), .ram_b_wmask_o(b_wmask), .ram_b_rdata_i(b_rdata)
  );

  ram_2p_arbiter #(.Width(W), .Depth(5), .NumReq(NR)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .init_req_i(init5), .init_busy_o(busy5), .init_done_o(done5),
    .req_i('0), .write_i('0), .addr_i('0), .wdata_i('0), .wmask_i('0),
    .gnt_o(gnt5), .rvalid_o(rvalid5), .rdata_o(rdata5),
    .ram_a_req_o(a_req5), .ram_a_write_o(a_wr5), .ram_a_addr_o(a_addr5),
    .ram_a_wdata_o(a_wdata5), .ram_a_wmask_o(a_wmask5), .ram_a_rdata_i('0),
    .ram_b_req_o(b_req5), .ram_b_write_o(b_wr5), .ram_b_addr_o(b_addr5),
    .ram_b_wdata_o(b_wdata5), .ram_b_wmask_o(b_wmask5), .ram_b_rdata_i('0)
  );

  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (a_req) begin
      if (a_wr) mem[a_addr] <= (mem[a_addr] & ~a_wmask) | (a_wdata & a_wmask);
      else      a_rdata     <= mem[a_addr];
    end
    if (b_req) begin
      if (b_wr) mem[b_addr] <= (mem[b_addr] & ~b_wmask) | (b_wdata & b_wmask);
      else      b_rdata     <= mem[b_addr];
    end
  end

  int checks = 0, errors = 0, nresp = 0, mon_idx;

  typedef struct {
    int           k;
    logic [W-1:0] d;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest queued expectation for that requester.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NR; k++) begin
        if (rvalid[k]) begin
          mon_idx = -1;
          foreach (sb[i]) if (mon_idx < 0 && sb[i].k == k) mon_idx = i;
          if (mon_idx < 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected req=%0d actual=1 expected=0", k);
          end else begin
            chk($sformatf("rdata%0d", k), 64'(rdata[k*W +: W]), 64'(sb[mon_idx].d));
            sb.delete(mon_idx);
            nresp++;
          end
        end
      end
    end
  end

  task automatic cycle_chk(input string nm, input logic [NR-1:0] eg, input int ea, input int eb);
    @(negedge clk);
    chk({nm, "_gnt"}, 64'(gnt), 64'(eg));
    if (ea >= 0) begin
      chk({nm, "_a_req"}, 64'(a_req), 64'd1);
      chk({nm, "_a_addr"}, 64'(a_addr), 64'(ea));
    end
    if (eb >= 0) begin
      chk({nm, "_b_req"}, 64'(b_req), 64'd1);
      chk({nm, "_b_addr"}, 64'(b_addr), 64'(eb));
    end else if (eb == -2) begin
      chk({nm, "_b_idle"}, 64'(b_req), 64'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++)
      if (eg[k] && !wr[k]) sb.push_back('{k, s_exp[k]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_init(input string nm);
    int n;
    n = 0;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    req = '1;
    wr  = '0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      chk({nm, "_gnt_zero"}, 64'(gnt), 64'd0);
      if (n == 0) begin
        chk({nm, "_a_write"}, 64'({a_req, a_wr, a_wdata == 0, a_addr}), 64'({3'b111, 7'd0}));
        chk({nm, "_b_write"}, 64'({b_req, b_wr, b_wdata == 0, b_addr}), 64'({3'b111, 7'd1}));
      end
      init_req = (n == 5);
      n++;
    end
    req      = '0;
    init_req = 1'b0;
    chk({nm, "_busy_cycles"}, 64'(n), 64'd64);
    chk({nm, "_done"}, 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int next, cyc, start, n;
    logic [NR-1:0] g;
    init_req = 1'b0;
    init5    = 1'b0;
    req      = '0;
    wr       = '0;
    for (int k = 0; k < NR; k++) begin
      s_addr[k] = '0; s_wdata[k] = '0; s_exp[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ram_req", 64'({a_req, b_req}), 64'd0);
    chk("rst_rdata_zero", 64'(rdata == '0), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_init("init1");

    // Read back every word after the wipe.
    next = 0; cyc = 0; start = nresp;
    while ((next < D || req != '0) && cyc < 500) begin
      for (int k = 0; k < NR; k++)
        if (!req[k] && next < D) begin
          req[k] = 1'b1; wr[k] = 1'b0; s_addr[k] = 7'(next); s_exp[k] = '0; next++;
        end
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      for (int k = 0; k < NR; k++)
        if (g[k]) begin
          sb.push_back('{k, 32'h0});
          req[k] = 1'b0;
        end
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bulk_read_count", 64'(nresp - start), 64'd128);

    // Reset in the middle of a second wipe.
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("mid_init_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_ram_req", 64'({a_req, b_req}), 64'd0);
    chk("arst_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_init("init2");

    // Depth=5 instance: three cycles, last one writes only word 4 on port A.
    init5 = 1'b1;
    @(posedge clk); #1;
    init5 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!busy5) break;
      if (n == 0) chk("d5_c0_b", 64'({b_req5, b_addr5}), 64'({1'b1, 3'd1}));
      if (n == 2) begin
        chk("d5_last_a", 64'({a_req5, a_wr5, a_addr5}), 64'({2'b11, 3'd4}));
        chk("d5_last_b_idle", 64'(b_req5), 64'd0);
      end
      n++;
    end
    chk("d5_cycles", 64'(n), 64'd3);
    chk("d5_done", 64'(done5), 64'd1);
    @(posedge clk); #1;

    // All four requesters: write 20..23, then read them back four cycles running.
    do_reset();
    for (int k = 0; k < NR; k++) begin
      s_addr[k] = 7'(20 + k); s_wdata[k] = 32'hA0 + k; s_exp[k] = 32'hA0 + k;
    end
    req = '1; wr = '1;
    cycle_chk("wr01", 4'b0011, 20, 21);
    req[1:0] = 2'b00;
    cycle_chk("wr23", 4'b1100, 22, 23);
    req = '1; wr = '0;
    cycle_chk("rd_c1", 4'b0011, 20, 21);
    cycle_chk("rd_c2", 4'b1100, 22, 23);
    cycle_chk("rd_c3", 4'b0011, 20, 21);
    cycle_chk("rd_c4", 4'b1100, 22, 23);
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // Write then read back through a different requester.
    do_reset();
    req = 4'b0001; wr = 4'b0001; s_addr[0] = 7'd5; s_wdata[0] = 32'hDEADBEEF;
    cycle_chk("w5", 4'b0001, 5, -2);
    req = 4'b0100; wr = 4'b0000; s_addr[2] = 7'd5; s_exp[2] = 32'hDEADBEEF;
    cycle_chk("r5", 4'b0100, 5, -2);
    req = '0;
    @(negedge clk);
    chk("r5_rvalid", 64'(rvalid), 64'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r5_rvalid_once", 64'(rvalid), 64'd0);
    @(posedge clk); #1;

    // Same-address hazard: req1 writes addr 9 while req3 reads it.
    do_reset();
    req = 4'b1010; wr = 4'b0010;
    s_addr[1] = 7'd9; s_wdata[1] = 32'h12345678;
    s_addr[3] = 7'd9; s_exp[3]   = 32'h12345678;
    cycle_chk("haz1", 4'b0010, 9, -2);
    req[1] = 1'b0;
    cycle_chk("haz2", 4'b1000, 9, -2);
    req = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("d5_no_rvalid", 64'(rvalid5 | gnt5), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
